// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types, constants and width helper for the perceptron accumulator
package perceptron_pkg;

  localparam int W    = 32;
  localparam int FRAC = 16;

  localparam logic signed [W-1:0] ONE_Q   = W'(1) << FRAC;
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} acc_state_t;

  // Guard width: product width plus enough headroom for bias + NUM_INPUTS products.
  function automatic int acc_width(input int num_inputs, input int w, input int frac);
    return 2 * w - frac + $clog2(num_inputs + 1) + 1;
  endfunction

endpackage

// File: rtl/fixed_point_multiplier.sv
// rtl/fixed_point_multiplier.sv - registered signed fixed-point multiply, floor-rounded by Q_N
module fixed_point_multiplier
  import perceptron_pkg::*;
#(
  parameter int  SIGN = 1,
  parameter int  Q_M  = 15,
  parameter int  Q_N  = 16,
  localparam int DW   = SIGN + Q_M + Q_N,
  localparam int PW   = 2 * DW - Q_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic                 o_valid,
  output logic signed [PW-1:0] o_p
);

  logic signed [2*DW-1:0] w_full;
  logic signed [PW-1:0]   r_p;
  logic                   r_valid;

  assign w_full = i_a * i_b;

  // Arithmetic shift of the full product floors toward -inf; PW bits hold every result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_p <= PW'(w_full >>> Q_N);
    end
  end

  assign o_p     = r_p;
  assign o_valid = r_valid;

endmodule

// File: rtl/perceptron_accumulator.sv
// rtl/perceptron_accumulator.sv - bias + sum(x*w) with guard accumulator and saturated, handshaked output
module perceptron_accumulator
  import perceptron_pkg::*;
#(
  parameter int SIGN       = 1,
  parameter int Q_M        = 15,
  parameter int Q_N        = 16,
  parameter int NUM_INPUTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SIGN+Q_M+Q_N-1:0]    bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIGN+Q_M+Q_N-1:0]    in_x,
  input  logic [SIGN+Q_M+Q_N-1:0]    in_w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIGN+Q_M+Q_N-1:0]    summation,
  output logic                       busy
);

  localparam int DW = SIGN + Q_M + Q_N;
  localparam int PW = 2 * DW - Q_N;
  localparam int AW = acc_width(NUM_INPUTS, DW, Q_N);
  localparam int CW = $clog2(NUM_INPUTS + 1);

  localparam logic signed [AW-1:0] ACC_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  acc_state_t r_state, w_state_nxt;

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_acc_nxt;
  logic        [CW-1:0] r_count;
  logic        [DW-1:0] r_sum;
  logic        [DW-1:0] w_sat;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_prod_valid;
  logic signed [PW-1:0] w_prod;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign summation = r_sum;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_count == CW'(NUM_INPUTS - 1));

  fixed_point_multiplier #(
    .SIGN (SIGN),
    .Q_M  (Q_M),
    .Q_N  (Q_N)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .i_a     (in_x),
    .i_b     (in_w),
    .o_valid (w_prod_valid),
    .o_p     (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ACCUM;
      ACCUM:   if (w_accept && w_last) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc_nxt = r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};

  // The last product lands in DRAIN, so the output is clamped from the next-acc value.
  always_comb begin
    if (w_acc_nxt > ACC_MAX)      w_sat = {1'b0, {(DW-1){1'b1}}};
    else if (w_acc_nxt < ACC_MIN) w_sat = {1'b1, {(DW-1){1'b0}}};
    else                          w_sat = w_acc_nxt[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sum   <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_acc   <= {{(AW-DW){bias[DW-1]}}, bias};
        r_count <= '0;
      end else if (w_prod_valid) begin
        r_acc <= w_acc_nxt;
      end
      if (w_accept) r_count <= r_count + CW'(1);
      if (r_state == DRAIN) r_sum <= w_sat;
    end
  end

endmodule

// File: tb/tb_perceptron_accumulator.sv
// tb/tb_perceptron_accumulator.sv - randomized self-checking bench against a behavioural Q15.16 model
module tb_perceptron_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s     [3];
  logic [31:0] bias_s      [3];
  logic        in_valid_s  [3];
  logic [31:0] in_x_s      [3];
  logic [31:0] in_w_s      [3];
  logic        out_ready_s [3];
  wire  [2:0]  rdy;
  wire  [2:0]  ov;
  wire  [2:0]  bsy;
  wire  [31:0] sum_s [3];

  logic [31:0] px [8];
  logic [31:0] pw [8];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Instance 0: NUM_INPUTS=2, instance 1: NUM_INPUTS=1, instance 2: NUM_INPUTS=8.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    perceptron_accumulator #(
      .SIGN       (1),
      .Q_M        (15),
      .Q_N        (16),
      .NUM_INPUTS ((g == 0) ? 2 : (g == 1) ? 1 : 8)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s[g]),
      .bias      (bias_s[g]),
      .in_valid  (in_valid_s[g]),
      .in_ready  (rdy[g]),
      .in_x      (in_x_s[g]),
      .in_w      (in_w_s[g]),
      .out_valid (ov[g]),
      .out_ready (out_ready_s[g]),
      .summation (sum_s[g]),
      .busy      (bsy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] b, input int n);
    longint s;
    longint maxv;
    longint minv;
    maxv = 2147483647;
    minv = -maxv - 1;
    s = longint'($signed(b));
    for (int i = 0; i < n; i++)
      s += (longint'($signed(px[i])) * longint'($signed(pw[i]))) >>> 16;
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
    return s[31:0];
  endfunction

  function automatic logic [31:0] rnd_q();
    logic [31:0] v;
    v = $urandom;
    return $signed(v) >>> $urandom_range(0, 20);
  endfunction

  // One full summation on instance d; poke pulses start during ACCUM, DONE and the final handshake.
  task automatic run_sum(input int d, input int n, input logic [31:0] b, input bit gaps,
                         input int hold, input bit poke, output logic [31:0] res);
    int k;
    int cyc;
    int lat;
    bit take;
    logic [31:0] held;
    k = 0;
    cyc = 0;
    start_s[d] = 1'b1;
    bias_s[d]  = b;
    tick();
    start_s[d] = 1'b0;
    bias_s[d]  = ~b;
    while (k < n && cyc < 200) begin
      in_valid_s[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_x_s[d]     = px[k];
      in_w_s[d]     = pw[k];
      start_s[d]    = poke && (cyc == 1);
      take          = in_valid_s[d] && rdy[d];
      tick();
      cyc++;
      if (take) k++;
    end
    start_s[d]    = 1'b0;
    in_valid_s[d] = 1'b0;
    check("accepts", 64'(k), 64'(n));
    if (!gaps) check("throughput_cycles", 64'(cyc), 64'(n));
    lat = 1;
    while (!ov[d] && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd2);
    res  = sum_s[d];
    held = sum_s[d];
    for (int i = 0; i < hold; i++) begin
      start_s[d] = poke && (i == 0);
      tick();
      start_s[d] = 1'b0;
      check("hold_valid", 64'(ov[d]), 64'd1);
      check("hold_sum", 64'(sum_s[d]), 64'(held));
    end
    start_s[d]     = poke;
    out_ready_s[d] = 1'b1;
    tick();
    out_ready_s[d] = 1'b0;
    start_s[d]     = 1'b0;
    check("release_idle", 64'({ov[d], bsy[d], rdy[d]}), 64'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] b;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; bias_s[d] = '0; in_valid_s[d] = 1'b0;
      in_x_s[d] = '0; in_w_s[d] = '0; out_ready_s[d] = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check("reset_outputs", 64'({ov[d], rdy[d], bsy[d]}), 64'd0);
      check("reset_sum", 64'(sum_s[d]), 64'd0);
    end
    rst_n = 1'b1;
    tick();

    px[0] = 32'h0001_0000; pw[0] = 32'h0000_8000;
    px[1] = 32'h0002_0000; pw[1] = 32'hFFFF_0000;
    run_sum(0, 2, 32'h0000_4000, 1'b0, 0, 1'b0, res);
    check("basic_sum", 64'(res), 64'hFFFE_C000);

    px[0] = 32'h7FFF_0000; pw[0] = 32'h7FFF_0000;
    px[1] = 32'h7FFF_0000; pw[1] = 32'h7FFF_0000;
    run_sum(0, 2, 32'h0, 1'b0, 0, 1'b0, res);
    check("sat_pos", 64'(res), 64'h7FFF_FFFF);
    pw[0] = 32'h8001_0000; pw[1] = 32'h8001_0000;
    run_sum(0, 2, 32'h0, 1'b0, 0, 1'b0, res);
    check("sat_neg", 64'(res), 64'h8000_0000);

    px[0] = 32'h0000_0001; pw[0] = 32'h0000_8000;
    run_sum(1, 1, 32'h0, 1'b0, 0, 1'b0, res);
    check("floor_pos", 64'(res), 64'h0);
    px[0] = 32'hFFFF_FFFF;
    run_sum(1, 1, 32'h0, 1'b0, 0, 1'b0, res);
    check("floor_neg", 64'(res), 64'hFFFF_FFFF);

    px[0] = 32'h0003_0000; pw[0] = 32'h0000_4000;
    px[1] = 32'hFFFE_0000; pw[1] = 32'h0001_8000;
    run_sum(0, 2, 32'h0001_0000, 1'b1, 5, 1'b1, res);
    check("handshake_sum", 64'(res), 64'(ref_model(32'h0001_0000, 2)));

    px[0] = 32'h0005_0000; pw[0] = 32'h0001_0000;
    start_s[0] = 1'b1; bias_s[0] = 32'h0000_1234;
    tick();
    start_s[0] = 1'b0; in_valid_s[0] = 1'b1; in_x_s[0] = px[0]; in_w_s[0] = pw[0];
    tick();
    in_valid_s[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({ov[0], rdy[0], bsy[0]}), 64'd0);
    check("midrst_sum", 64'(sum_s[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_no_stale", 64'({ov[0], bsy[0]}), 64'd0);
    px[0] = '0; pw[0] = '0; px[1] = '0; pw[1] = '0;
    run_sum(0, 2, 32'h0001_0000, 1'b0, 0, 1'b0, res);
    check("post_rst_sum", 64'(res), 64'h0001_0000);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) begin
        px[i] = rnd_q();
        pw[i] = rnd_q();
      end
      b = rnd_q();
      run_sum(2, 8, b, 1'b0, 0, 1'b0, res);
      check("n8_model", 64'(res), 64'(ref_model(b, 8)));
    end

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 2; i++) begin
        px[i] = rnd_q();
        pw[i] = rnd_q();
      end
      b = rnd_q();
      run_sum(0, 2, b, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res);
      check("n2_model", 64'(res), 64'(ref_model(b, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
